// File: rtl/irq_ctrl.sv
// IRQ entry/exit sequencer: synchronises the IRQ line, enters the handler at an
// instruction boundary and drives the SPSR/LR/flush/redirect actions.
module irq_ctrl #(
  parameter logic [31:0] VECTOR      = 32'h0000_0018,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        i_irq,
  input  logic        i_irq_mask,
  input  logic        i_int_mode,
  input  logic        i_insn_boundary,
  input  logic [31:0] i_pc_next,
  input  logic        i_exc_ret,
  output logic        o_spsr_bak,
  output logic        o_spsr_res,
  output logic        o_flush,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_lr_we,
  output logic [31:0] o_lr_data,
  output logic        o_irq_ack,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   irq_s;
  logic                   take;
  logic                   entry_q;
  logic                   busy_q;
  logic [31:0]            lr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (en) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_irq};
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];
  assign take  = (state == IDLE) & irq_s & ~i_irq_mask & ~i_int_mode & i_insn_boundary;

  // Entry strobes and busy are registered alongside the state so they never glitch on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      entry_q <= 1'b0;
      busy_q  <= 1'b0;
      lr_q    <= 32'd0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (take) begin
            state   <= ENTER;
            entry_q <= 1'b1;
            busy_q  <= 1'b1;
            lr_q    <= i_pc_next + 32'd4;
          end
        end
        ENTER: begin
          state   <= HANDLER;
          entry_q <= 1'b0;
        end
        HANDLER: begin
          if (i_exc_ret) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          entry_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Restore is combinational so it lands on the same edge as the return commit.
  assign o_spsr_res    = (state == HANDLER) & i_exc_ret;
  assign o_spsr_bak    = entry_q;
  assign o_flush       = entry_q;
  assign o_redirect    = entry_q;
  assign o_lr_we       = entry_q;
  assign o_irq_ack     = entry_q;
  assign o_busy        = busy_q;
  assign o_redirect_pc = VECTOR;
  assign o_lr_data     = lr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl, checked every cycle against a
// behavioural model of the interrupt entry/return sequence.
module tb_irq_ctrl;
  localparam logic [31:0] VEC = 32'h0000_0018;
  localparam int          SS  = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, i_irq, i_irq_mask, i_int_mode, i_insn_boundary, i_exc_ret;
  logic [31:0] i_pc_next;
  logic        o_spsr_bak, o_spsr_res, o_flush, o_redirect, o_lr_we, o_irq_ack, o_busy;
  logic [31:0] o_redirect_pc, o_lr_data;

  int checks = 0;
  int passes = 0;

  // Model: sampled IRQ history, "entry cycle" flag, "inside handler" flag, saved LR.
  bit          m_hist[$];
  bit          m_entry;
  bit          m_isr;
  logic [31:0] m_lr;

  always #5 clk = ~clk;

  irq_ctrl #(.VECTOR(VEC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .i_irq(i_irq), .i_irq_mask(i_irq_mask),
    .i_int_mode(i_int_mode), .i_insn_boundary(i_insn_boundary), .i_pc_next(i_pc_next),
    .i_exc_ret(i_exc_ret), .o_spsr_bak(o_spsr_bak), .o_spsr_res(o_spsr_res),
    .o_flush(o_flush), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_lr_we(o_lr_we), .o_lr_data(o_lr_data), .o_irq_ack(o_irq_ack), .o_busy(o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    m_hist.delete();
    m_entry = 1'b0;
    m_isr   = 1'b0;
    m_lr    = 32'd0;
  endtask

  // The synchronised IRQ is whatever was sampled SS enabled edges back.
  function automatic bit modelIrqS();
    if (m_hist.size() < SS) return 1'b0;
    return m_hist[m_hist.size() - SS];
  endfunction

  task automatic modelEdge();
    bit irq_s;
    if (!rst_n || !en) return;
    irq_s = modelIrqS();
    if (m_entry) m_entry = 1'b0;
    else if (m_isr) begin
      if (i_exc_ret) m_isr = 1'b0;
    end else if (irq_s && !i_irq_mask && !i_int_mode && i_insn_boundary) begin
      m_entry = 1'b1;
      m_isr   = 1'b1;
      m_lr    = i_pc_next + 32'd4;
    end
    m_hist.push_back(i_irq);
    if (m_hist.size() > SS) void'(m_hist.pop_front());
  endtask

  task automatic checkOutput();
    check("spsr_bak",    {31'd0, o_spsr_bak}, {31'd0, m_entry});
    check("flush",       {31'd0, o_flush},    {31'd0, m_entry});
    check("redirect",    {31'd0, o_redirect}, {31'd0, m_entry});
    check("lr_we",       {31'd0, o_lr_we},    {31'd0, m_entry});
    check("irq_ack",     {31'd0, o_irq_ack},  {31'd0, m_entry});
    check("busy",        {31'd0, o_busy},     {31'd0, (m_entry | m_isr)});
    check("spsr_res",    {31'd0, o_spsr_res}, {31'd0, (m_isr & ~m_entry & i_exc_ret)});
    check("redirect_pc", o_redirect_pc, VEC);
    check("lr_data",     o_lr_data, m_lr);
  endtask

  task automatic applyStimulus(input logic e, input logic irq, input logic mask, input logic mode,
                               input logic bnd, input logic [31:0] pc, input logic xr);
    @(negedge clk);
    en = e; i_irq = irq; i_irq_mask = mask; i_int_mode = mode;
    i_insn_boundary = bnd; i_pc_next = pc; i_exc_ret = xr;
    #1 checkOutput();
    @(posedge clk);
    modelEdge();
  endtask

  // Return from a handler with the mask set and the IRQ line dropped, then drain the synchroniser.
  task automatic returnAndDrain();
    applyStimulus(1, 0, 1, 0, 1, 32'h0, 1);
    repeat (3) applyStimulus(1, 0, 1, 0, 1, 32'h0, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; i_irq = 1'b0; i_irq_mask = 1'b1; i_int_mode = 1'b0;
    i_insn_boundary = 1'b0; i_pc_next = 32'd0; i_exc_ret = 1'b0;
    modelReset();
    #12;
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ack", {31'd0, o_irq_ack}, 32'd0);
    check("rst_lr_data", o_lr_data, 32'd0);
    check("rst_redirect_pc", o_redirect_pc, 32'h18);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic entry: vector reached on the third enabled edge.
    applyStimulus(1, 1, 0, 0, 1, 32'h100, 0);
    applyStimulus(1, 1, 0, 0, 1, 32'h100, 0);
    #2 check("basic_no_early_ack", {31'd0, o_irq_ack}, 32'd0);
    applyStimulus(1, 1, 0, 0, 1, 32'h100, 0);
    #2;
    check("basic_ack", {31'd0, o_irq_ack}, 32'd1);
    check("basic_flush", {31'd0, o_flush}, 32'd1);
    check("basic_lr_data", o_lr_data, 32'h104);
    applyStimulus(1, 1, 0, 0, 1, 32'h100, 0);
    #2;
    check("basic_handler_busy", {31'd0, o_busy}, 32'd1);
    check("basic_handler_ack", {31'd0, o_irq_ack}, 32'd0);

    // Return, then exception-return pulses in IDLE are ignored.
    returnAndDrain();
    #2 check("return_idle", {31'd0, o_busy}, 32'd0);
    repeat (3) applyStimulus(1, 0, 0, 0, 1, 32'h0, 1);

    // Masked for 20 cycles, then unmasked: entry on the next edge.
    repeat (20) applyStimulus(1, 1, 1, 0, 1, 32'h300, 0);
    #2 check("masked_no_entry", {31'd0, o_busy}, 32'd0);
    applyStimulus(1, 1, 0, 0, 1, 32'h300, 0);
    #2 check("unmask_entry", {31'd0, o_irq_ack}, 32'd1);
    check("unmask_lr", o_lr_data, 32'h304);
    applyStimulus(1, 1, 0, 0, 1, 32'h300, 0);
    returnAndDrain();

    // Already in IRQ mode, or no boundary: never taken.
    repeat (10) applyStimulus(1, 1, 0, 1, 1, 32'h400, 0);
    repeat (10) applyStimulus(1, 1, 0, 0, 0, 32'h400, 0);
    #2 check("blocked_no_entry", {31'd0, o_busy}, 32'd0);
    repeat (3) applyStimulus(1, 0, 1, 0, 1, 32'h0, 0);

    // Stall in ENTER: strobes and LR held while en is low.
    repeat (3) applyStimulus(1, 1, 0, 0, 1, 32'h200, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 32'h500, 0);
      #2;
      check("stall_ack", {31'd0, o_irq_ack}, 32'd1);
      check("stall_lr", o_lr_data, 32'h204);
    end
    applyStimulus(1, 1, 0, 0, 1, 32'h500, 0);
    #2;
    check("stall_release_ack", {31'd0, o_irq_ack}, 32'd0);
    check("stall_release_busy", {31'd0, o_busy}, 32'd1);
    check("stall_release_lr", o_lr_data, 32'h204);

    // Asynchronous reset inside the handler.
    @(negedge clk);
    i_irq = 1'b0; i_exc_ret = 1'b1;
    #1 check("pre_reset_spsr_res", {31'd0, o_spsr_res}, 32'd1);
    rst_n = 1'b0;
    #1;
    modelReset();
    check("reset_spsr_res", {31'd0, o_spsr_res}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_lr", o_lr_data, 32'd0);
    i_exc_ret = 1'b0;
    #1 rst_n = 1'b1;

    // LR wraps past the top of the address space.
    repeat (3) applyStimulus(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0);
    #2;
    check("wrap_ack", {31'd0, o_irq_ack}, 32'd1);
    check("wrap_lr", o_lr_data, 32'h0);
    applyStimulus(1, 1, 0, 0, 1, 32'h0, 0);
    returnAndDrain();

    // Randomised traffic against the model.
    begin
      logic irq_r;
      irq_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic [31:0] pc;
        if ($urandom_range(0, 9) == 0) irq_r = ~irq_r;
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        applyStimulus($urandom_range(0, 9) < 8,
                      irq_r,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) < 7,
                      pc,
                      $urandom_range(0, 4) == 0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

IRQ entry/exit sequencer for the ARMv4 core. It synchronises the external IRQ line, takes the interrupt at an instruction boundary when the CPSR state allows it, and drives the entry actions: SPSR backup, LR_irq write, pipeline flush and PC redirect to the IRQ vector. It consumes `o_irq_mask` / `o_int_mode` from the CPSR block. It produces that block's `i_spsr_bak` / `i_spsr_res` strobes.

## Interface
- `VECTOR`, 32'h0000_0018, IRQ vector address driven on redirect.
- `SYNC_STAGES`, 2, flops in the `i_irq` synchroniser (≥2).
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: core advance enable. All state, including the synchroniser, holds when low.
- `i_irq` in 1: external IRQ request, level-sensitive, asynchronous to `clk`.
- `i_irq_mask` in 1: CPSR I bit (1 = masked).
- `i_int_mode` in 1: CPSR mode bit (1 = in IRQ mode).
- `i_insn_boundary` in 1: pipeline can be interrupted this cycle (EX holds a completed instruction, no branch in flight).
- `i_pc_next` in 32: address of the next instruction that would execute.
- `i_exc_ret` in 1: an exception-return instruction (S-bit write to PC) commits this cycle.
- `o_spsr_bak` out 1: one-cycle strobe to CPSR (save CPSR→SPSR, enter IRQ mode).
- `o_spsr_res` out 1: one-cycle strobe to CPSR (restore SPSR→CPSR).
- `o_flush` out 1: kill IF/ID/EX contents.
- `o_redirect` out 1: load PC with `o_redirect_pc`.
- `o_redirect_pc` out 32: equals `VECTOR`.
- `o_lr_we` out 1: write LR_irq.
- `o_lr_data` out 32: `i_pc_next + 4`, registered.
- `o_irq_ack` out 1: one-cycle acknowledge, coincident with entry.
- `o_busy` out 1: high in ENTER or HANDLER.

## Operation
- **Synchroniser:** `SYNC_STAGES`-deep shift of `i_irq`. `irq_s` is the last stage.
- **Take condition:** `take = irq_s & ~i_irq_mask & ~i_int_mode & i_insn_boundary`, evaluated in IDLE only.
- **FSM states:** IDLE, ENTER, HANDLER. All transitions happen only on edges with `en=1`.
  - IDLE → ENTER when `take`. On the same edge, latch `lr_q = i_pc_next + 4` (32-bit wrap, carry dropped).
  - ENTER → HANDLER unconditionally.
  - HANDLER → IDLE when `i_exc_ret`.
  - HANDLER otherwise holds.
- **Outputs are decoded from registered state, not combinational on inputs.**
  - In ENTER: `o_spsr_bak = o_flush = o_redirect = o_lr_we = o_irq_ack = 1`.
  - In HANDLER with `i_exc_ret = 1`: `o_spsr_res = 1`. This output is combinational on `i_exc_ret`, gated by state, so the CPSR restore and the return commit land on the same edge.
  - `i_exc_ret` in IDLE or ENTER is ignored: `o_spsr_res` stays 0 and there is no state change.
- **No nesting:** while in HANDLER, a level IRQ is not taken even if the handler clears the I bit. Re-entry is evaluated only after returning to IDLE.
- **Interrupt still asserted at return:** if `irq_s` is still high after return and the restored mask is 0, it is taken again at the next boundary. The CPSR restore is visible on `i_irq_mask` from the cycle after `o_spsr_res`.
- `o_redirect_pc` is constant `VECTOR`.
- `o_lr_data` is `lr_q`, stable from ENTER until the next entry.
- **Reset:** all state clears to IDLE.

## Timing
- **Reset values:** state = IDLE, sync flops = 0, `lr_q` = 0. Every output is 0 except `o_redirect_pc = VECTOR`.
- **Synchroniser latency:** `i_irq` rising before edge k makes `irq_s` = 1 after edge k+SYNC_STAGES-1, counting `en=1` edges only.
- **Entry latency:** ENTER is entered on the first enabled edge where `take = 1`. Entry strobes last exactly one cycle, or extend while `en=0`. The CPSR block consumes `o_spsr_bak` only when `en=1`.
- **Minimum IRQ-to-vector latency:** SYNC_STAGES + 1 enabled edges, with mask clear and boundary continuously high.
- **Reset mid-operation:** asserting `rst_n=0` in ENTER or HANDLER returns to IDLE immediately (asynchronously). All strobes drop in the same cycle.
- **Simultaneous `take` and `i_exc_ret` in IDLE:** entry proceeds and `i_exc_ret` is ignored.
- **`en=0` in HANDLER with `i_exc_ret=1`:** `o_spsr_res` is still driven, but no transition occurs. The return is taken on the enabled edge.

## Test plan
- **Basic entry:** reset, `i_irq_mask=0`, `i_int_mode=0`, boundary=1, `i_pc_next=0x100`, raise `i_irq`.
  - ENTER is reached after 3 edges, with one cycle of `o_spsr_bak/o_flush/o_redirect/o_lr_we/o_irq_ack`, `o_lr_data=0x104`, `o_redirect_pc=0x18`.
  - State is HANDLER the next cycle.
- **Masked or blocked:** `i_irq=1` with `i_irq_mask=1` for 20 cycles → no strobes.
  - Clear the mask → entry occurs on the next enabled edge.
  - Repeat with `i_int_mode=1`, and with boundary=0: no entry in either case.
- **Return:** in HANDLER, pulse `i_exc_ret` → `o_spsr_res=1` in that cycle, IDLE on the next edge.
  - `i_exc_ret` pulsed in IDLE → `o_spsr_res` stays 0.
- **Stall:** hold `en=0` during ENTER for 3 cycles → strobes stay high and the state is unchanged.
  - Release → HANDLER after one edge. `lr_q` is unchanged throughout.
- **Reset mid-handler and LR wrap:** assert `rst_n=0` in HANDLER → all outputs 0 immediately, IDLE after release.
  - Entry with `i_pc_next=0xFFFF_FFFC` → `o_lr_data=0x0000_0000`.
